dff_response_checker: RTL and testbench

Synthesizable response checker for single-cycle-latency storage elements (D flip-flops, register stages). It sits beside a device under test and consumes the same stimulus the driver applies. It models the expected output with its own reset-aware delay line, compares against the observed output for a programmed number of cycles, and reports pass/fail, error counts and the index of the first mismatch. It is the receiving end of the stimulus/response interface used by the team's flop-level benches.

---
 rtl/dff_response_checker_if.sv | 34 +++
 rtl/dff_response_checker.sv | 134 +++++++++++++
 tb/tb_dff_response_checker.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/dff_response_checker_if.sv
`default_nettype none
// ============================================================
// dff_response_checker_if : stimulus/response bus between a flop
//   bench driver and the response checker.          Rev 1.0
// ============================================================
interface dff_response_checker_if #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16,
  parameter int ERR_W = 8
);
  logic             start;
  logic [CNT_W-1:0] num_checks;
  logic             dut_rst;
  logic [WIDTH-1:0] d_stim;
  logic [WIDTH-1:0] q_obs;
  logic             busy;
  logic             done;
  logic             pass;
  logic             fail;
  logic [ERR_W-1:0] err_count;
  logic [CNT_W-1:0] chk_count;
  logic [CNT_W-1:0] first_err_idx;

  modport master (
    output start, num_checks, dut_rst, d_stim, q_obs,
    input  busy, done, pass, fail, err_count, chk_count, first_err_idx
  );

  modport slave (
    input  start, num_checks, dut_rst, d_stim, q_obs,
    output busy, done, pass, fail, err_count, chk_count, first_err_idx
  );
endinterface
`default_nettype wire

// File: rtl/dff_response_checker.sv
`default_nettype none
// ============================================================
// dff_response_checker : reset-aware expected-value delay line
//   plus compare FSM for flop-level DUTs.            Rev 1.0
// ============================================================
module dff_response_checker #(
  parameter int WIDTH   = 1,
  parameter int LATENCY = 1,
  parameter int CNT_W   = 16,
  parameter int ERR_W   = 8
) (
  input  wire logic              clk,
  input  wire logic              reset,
  dff_response_checker_if.slave  bus
);

  localparam int              c_FILL_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam [c_FILL_W-1:0]   c_FILL_LAST = c_FILL_W'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_CHECK = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [c_FILL_W-1:0] fill_q, fill_d;
  logic [CNT_W-1:0]  num_q, num_d;
  logic [CNT_W-1:0]  chk_q, chk_d;
  logic [CNT_W-1:0]  idx_q, idx_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic              fail_q, fail_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic              mismatch;
  logic [WIDTH-1:0]  exp_q [LATENCY];

  // Model shifts every cycle independent of the FSM; dut_rst mirrors the DUT's own reset.
  always_ff @(posedge clk) begin
    if (reset || bus.dut_rst) begin
      for (int i = 0; i < LATENCY; i++) exp_q[i] <= '0;
    end else begin
      exp_q[0] <= bus.d_stim;
      for (int i = 1; i < LATENCY; i++) exp_q[i] <= exp_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      fill_q  <= '0;
      num_q   <= '0;
      chk_q   <= '0;
      idx_q   <= '0;
      err_q   <= '0;
      fail_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      num_q   <= num_d;
      chk_q   <= chk_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      fail_q  <= fail_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    fill_d   = fill_q;
    num_d    = num_q;
    chk_d    = chk_q;
    idx_d    = idx_q;
    err_d    = err_q;
    fail_d   = fail_q;
    mismatch = (bus.q_obs != exp_q[LATENCY-1]);

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d = S_FILL;
          fill_d  = '0;
          num_d   = bus.num_checks;
          chk_d   = '0;
          idx_d   = '0;
          err_d   = '0;
          fail_d  = 1'b0;
        end
      end
      S_FILL: begin
        if (fill_q == c_FILL_LAST) begin
          state_d = (num_q == '0) ? S_DONE : S_CHECK;
        end else begin
          fill_d = fill_q + 1'b1;
        end
      end
      S_CHECK: begin
        chk_d = chk_q + 1'b1;
        if (mismatch) begin
          if (err_q != '1) err_d = err_q + 1'b1;
          // Index is the pre-increment count, so the first compare is index 0.
          if (!fail_q) begin
            fail_d = 1'b1;
            idx_d  = chk_q;
          end
        end
        if (chk_d == num_q) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_FILL) || (state_d == S_CHECK);
    done_d = (state_d == S_DONE);
    pass_d = done_d && (err_d == '0);
  end

  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.pass          = pass_q;
  assign bus.fail          = fail_q;
  assign bus.err_count     = err_q;
  assign bus.chk_count     = chk_q;
  assign bus.first_err_idx = idx_q;

endmodule
`default_nettype wire

// File: tb/tb_dff_response_checker.sv
`default_nettype none
// ============================================================
// tb_dff_response_checker : randomized scoreboard bench for the
//   flop response checker.                           Rev 1.0
// ============================================================
module tb_dff_response_checker;

  localparam int W   = 4;
  localparam int LAT = 1;
  localparam int CW  = 16;
  localparam int EW  = 8;

  typedef struct {
    int pass_v;
    int fail_v;
    int err_v;
    int chk_v;
    int idx_v;
    int lat_v;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [W-1:0]  dev_q;
  logic [W-1:0]  corrupt;

  exp_t sb[$];
  bit   bad[int];
  int   n_total = 0;
  int   n_pass  = 0;
  int   cyc     = 0;
  int   busy_t  = 0;
  bit   pb      = 1'b0;
  bit   pd      = 1'b0;
  exp_t mon_e;

  dff_response_checker_if #(.WIDTH(W), .CNT_W(CW), .ERR_W(EW)) ifc();

  dff_response_checker #(
    .WIDTH(W), .LATENCY(LAT), .CNT_W(CW), .ERR_W(EW)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  always #5 clk = ~clk;

  // Ideal flop standing in for the DUT; corrupt flips bits on chosen compares.
  always @(posedge clk) dev_q <= ifc.dut_rst ? '0 : ifc.d_stim;
  assign ifc.q_obs = dev_q ^ corrupt;

  task automatic check(input string name, input int act, input int expv);
    n_total++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, expv);
  endtask

  function automatic logic [W-1:0] stim(input int mode);
    if (mode == 1) return '0;
    if (mode == 2) return W'(1);
    return W'($urandom);
  endfunction

  // Monitor: pops an expectation whenever done rises.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (ifc.busy && !pb) busy_t = cyc;
      if (ifc.done && !pd) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          mon_e = sb.pop_front();
          check("pass",          int'(ifc.pass),          mon_e.pass_v);
          check("fail",          int'(ifc.fail),          mon_e.fail_v);
          check("err_count",     int'(ifc.err_count),     mon_e.err_v);
          check("chk_count",     int'(ifc.chk_count),     mon_e.chk_v);
          check("first_err_idx", int'(ifc.first_err_idx), mon_e.idx_v);
          check("done_latency",  cyc - busy_t,            mon_e.lat_v);
        end
      end
      pb = ifc.busy;
      pd = ifc.done;
    end
  end

  // mode: 0 random stim, 1 stim 0, 2 stim 1. rst_at/restart_at are drive-cycle indices or -1.
  task automatic do_run(input int num, input int mode, input int rst_at, input int restart_at);
    exp_t e;
    int   nbad  = 0;
    int   first = -1;
    int   t     = 0;
    for (int k = 0; k < num; k++) begin
      if (bad.exists(k)) begin
        nbad++;
        if (first < 0) first = k;
      end
    end
    e.err_v  = (nbad > 255) ? 255 : nbad;
    e.fail_v = (nbad > 0) ? 1 : 0;
    e.idx_v  = (first < 0) ? 0 : first;
    e.chk_v  = num;
    e.pass_v = (nbad == 0) ? 1 : 0;
    e.lat_v  = LAT + num;
    sb.push_back(e);

    @(negedge clk);
    ifc.start      = 1'b1;
    ifc.num_checks = CW'(num);
    ifc.d_stim     = stim(mode);
    for (int j = 0; j < LAT + num; j++) begin
      @(negedge clk);
      ifc.start      = (j == restart_at);
      ifc.num_checks = (j == restart_at) ? CW'(5) : CW'(num);
      ifc.dut_rst    = (j == rst_at);
      ifc.d_stim     = stim(mode);
      corrupt        = (j >= LAT && bad.exists(j - LAT)) ? W'(1) : '0;
    end
    do begin
      @(negedge clk);
      ifc.start   = 1'b0;
      ifc.dut_rst = 1'b0;
      corrupt     = '0;
      t++;
    end while (!ifc.done && t < 6);
    check("done_seen", int'(ifc.done), 1);
  endtask

  initial begin
    int num;
    ifc.start      = 1'b0;
    ifc.num_checks = '0;
    ifc.dut_rst    = 1'b0;
    ifc.d_stim     = '0;
    corrupt        = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_busy", int'(ifc.busy), 0);
    check("rst_done", int'(ifc.done), 0);
    check("rst_pass", int'(ifc.pass), 0);
    check("rst_fail", int'(ifc.fail), 0);
    check("rst_err",  int'(ifc.err_count), 0);
    check("rst_chk",  int'(ifc.chk_count), 0);
    check("rst_idx",  int'(ifc.first_err_idx), 0);

    bad.delete();
    do_run(8, 0, -1, -1);
    bad[3] = 1'b1;
    do_run(8, 0, -1, -1);

    bad.delete();
    for (int k = 0; k < 300; k++) bad[k] = 1'b1;
    do_run(300, 1, -1, -1);

    bad.delete();
    do_run(10, 2, LAT + 3, -1);
    do_run(8, 0, -1, LAT + 2);

    // Abort mid-CHECK with errors accumulated; start collides with reset.
    @(negedge clk);
    ifc.start      = 1'b1;
    ifc.num_checks = CW'(20);
    corrupt        = W'(1);
    repeat (4) begin
      @(negedge clk);
      ifc.start  = 1'b0;
      ifc.d_stim = stim(0);
    end
    reset     = 1'b1;
    ifc.start = 1'b1;
    @(negedge clk);
    reset     = 1'b0;
    ifc.start = 1'b0;
    corrupt   = '0;
    check("abort_busy", int'(ifc.busy), 0);
    check("abort_done", int'(ifc.done), 0);
    check("abort_fail", int'(ifc.fail), 0);
    check("abort_err",  int'(ifc.err_count), 0);
    check("abort_chk",  int'(ifc.chk_count), 0);

    bad.delete();
    do_run(0, 0, -1, -1);

    for (int r = 0; r < 6; r++) begin
      num = int'($urandom_range(1, 40));
      bad.delete();
      for (int k = 0; k < num; k++) if ($urandom_range(0, 7) == 0) bad[k] = 1'b1;
      do_run(num, 0, -1, -1);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
